// File: rtl/upsample_nn_pkg.sv
// Shared types and widths for the up-sampling engine and its pooling sibling.
package upsample_pkg;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 16;
   localparam int DIM_W   = 6;
   localparam int SCALE_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      EMIT,
      DONE
   } state_e;

endpackage

// File: rtl/upsample_nn_if.sv
// Start/done handshake, configuration and SRAM port bundle for upsample_nn.
interface upsample_nn_if;
   import upsample_pkg::*;

   logic                     start;
   logic                     done;
   logic [ADDR_W-1:0]        src_start_address;
   logic [ADDR_W-1:0]        src_address;
   logic signed [DATA_W-1:0] src_readdata;
   logic                     src_write;
   logic [DIM_W-1:0]         src_row_size;
   logic [DIM_W-1:0]         src_col_size;
   logic [SCALE_W-1:0]       scale;
   logic [ADDR_W-1:0]        dest_start_address;
   logic [ADDR_W-1:0]        dest_address;
   logic signed [DATA_W-1:0] dest_writedata;
   logic                     dest_write_en;

   modport master (
      output start, src_start_address, src_readdata, src_row_size, src_col_size,
             scale, dest_start_address,
      input  done, src_address, src_write, dest_address, dest_writedata, dest_write_en
   );

   modport slave (
      input  start, src_start_address, src_readdata, src_row_size, src_col_size,
             scale, dest_start_address,
      output done, src_address, src_write, dest_address, dest_writedata, dest_write_en
   );

endinterface

// File: rtl/upsample_nn_addr_gen.sv
// Source-side walker: column / vertical-repeat / row counters and the source read address.
module upsample_addr_gen
   import upsample_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               init,
   input  logic               advance,
   input  logic [ADDR_W-1:0]  src_start_address,
   input  logic [DIM_W-1:0]   rows,
   input  logic [DIM_W-1:0]   cols,
   input  logic [SCALE_W-1:0] scale,
   output logic [ADDR_W-1:0]  src_address,
   output logic               last_col,
   output logic               last_row_rep,
   output logic               last_elem
);

   logic [DIM_W-1:0]   col_q, col_d;
   logic [DIM_W-1:0]   row_q, row_d;
   logic [SCALE_W-1:0] rep_q, rep_d;
   logic [ADDR_W-1:0]  row_base_q, row_base_d;
   logic [ADDR_W-1:0]  src_addr_q, src_addr_d;

   always_comb begin
      last_col     = (col_q == cols - DIM_W'(1));
      last_row_rep = (rep_q == scale - SCALE_W'(1));
      last_elem    = last_col && last_row_rep && (row_q == rows - DIM_W'(1));
   end

   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      rep_d      = rep_q;
      row_base_d = row_base_q;
      src_addr_d = src_addr_q;
      if (init) begin
         col_d      = '0;
         row_d      = '0;
         rep_d      = '0;
         row_base_d = src_start_address;
         src_addr_d = src_start_address;
      end else if (advance) begin
         if (!last_col) begin
            col_d      = col_q + DIM_W'(1);
            src_addr_d = src_addr_q + ADDR_W'(1);
         end else if (!last_row_rep) begin
            // Same source row again for the next vertical copy.
            col_d      = '0;
            rep_d      = rep_q + SCALE_W'(1);
            src_addr_d = row_base_q;
         end else begin
            col_d      = '0;
            rep_d      = '0;
            row_d      = row_q + DIM_W'(1);
            row_base_d = src_addr_q + ADDR_W'(1);
            src_addr_d = src_addr_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q      <= '0;
         row_q      <= '0;
         rep_q      <= '0;
         row_base_q <= src_start_address;
         src_addr_q <= src_start_address;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         rep_q      <= rep_d;
         row_base_q <= row_base_d;
         src_addr_q <= src_addr_d;
      end
   end

   assign src_address = src_addr_q;

endmodule

// File: rtl/upsample_nn.sv
// Nearest-neighbour up-sampler: each source word becomes an S x S block in the output map.
module upsample_nn
   import upsample_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   upsample_nn_if.slave bus
);

   state_e                   state_q, state_d;
   logic [DIM_W-1:0]         rows_q, cols_q;
   logic [SCALE_W-1:0]       scale_q;
   logic [SCALE_W-1:0]       emit_q, emit_d;
   logic signed [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0]        daddr_q, daddr_d;
   logic                     we_q, we_d;
   logic                     done_q, done_d;

   logic accept, zero_cfg, last_emit, advance;
   logic last_col, last_row_rep, last_elem;

   assign accept    = (state_q == IDLE) && bus.start;
   assign zero_cfg  = (bus.src_row_size == '0) || (bus.src_col_size == '0) || (bus.scale == '0);
   assign last_emit = (emit_q == scale_q - SCALE_W'(1));
   assign advance   = (state_q == EMIT) && last_emit;

   upsample_addr_gen u_addr_gen (
      .clk               (clk),
      .reset             (reset),
      .init              (state_q == IDLE),
      .advance           (advance),
      .src_start_address (bus.src_start_address),
      .rows              (rows_q),
      .cols              (cols_q),
      .scale             (scale_q),
      .src_address       (bus.src_address),
      .last_col          (last_col),
      .last_row_rep      (last_row_rep),
      .last_elem         (last_elem)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = zero_cfg ? DONE : FETCH;
         FETCH:   state_d = CAPTURE;
         CAPTURE: state_d = EMIT;
         EMIT:    if (last_emit) state_d = (last_col && last_row_rep && last_elem) ? DONE : FETCH;
         DONE:    if (!bus.start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered, so they are derived from the state being entered.
   always_comb begin
      we_d    = (state_d == EMIT);
      emit_d  = ((state_q == EMIT) && !last_emit) ? emit_q + SCALE_W'(1) : '0;
      data_d  = (state_q == CAPTURE) ? bus.src_readdata : data_q;
      daddr_d = daddr_q;
      if (state_q == IDLE)
         daddr_d = bus.dest_start_address;
      else if (we_q)
         daddr_d = daddr_q + ADDR_W'(1);
      done_d = done_q;
      if (state_d == DONE)
         done_d = 1'b1;
      else if (accept)
         done_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rows_q  <= '0;
         cols_q  <= '0;
         scale_q <= '0;
         emit_q  <= '0;
         data_q  <= '0;
         daddr_q <= bus.dest_start_address;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         if (accept) begin
            rows_q  <= bus.src_row_size;
            cols_q  <= bus.src_col_size;
            scale_q <= bus.scale;
         end
         emit_q  <= emit_d;
         data_q  <= data_d;
         daddr_q <= daddr_d;
         we_q    <= we_d;
         done_q  <= done_d;
      end
   end

   assign bus.done           = done_q;
   assign bus.src_write      = 1'b0;
   assign bus.dest_address   = daddr_q;
   assign bus.dest_writedata = data_q;
   assign bus.dest_write_en  = we_q;

endmodule

// File: tb/tb_upsample_nn.sv
// Randomized bench for upsample_nn against an output-index reference model.
module tb_upsample_nn;
   import upsample_pkg::*;

   localparam int MEM_N = 1 << ADDR_W;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail = 0;
   int   src_write_bad = 0;
   int   wr_addr_q[$];
   int   wr_data_q[$];
   logic signed [DATA_W-1:0] mem [MEM_N];

   upsample_nn_if bus();
   upsample_nn dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   always @(posedge clk) bus.src_readdata <= mem[bus.src_address];

   always @(negedge clk) begin
      if (bus.dest_write_en === 1'b1) begin
         wr_addr_q.push_back(int'(bus.dest_address));
         wr_data_q.push_back(int'(bus.dest_writedata));
      end
      if (bus.src_write !== 1'b0) src_write_bad++;
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic fill_map(input int base, input int n);
      for (int i = 0; i < n; i++) mem[(base + i) % MEM_N] = DATA_W'($urandom);
   endtask

   // Output word o sits at row o/(C*S), column o%(C*S); its source is (row/S, col/S).
   task automatic check_writes(input string tag, input int r, input int c, input int s,
                               input int src, input int dst);
      int total, n, orow, ocol, idx;
      total = r * s * c * s;
      check_val({tag, " nwrites"}, wr_addr_q.size(), total);
      n = (wr_addr_q.size() < total) ? wr_addr_q.size() : total;
      for (int o = 0; o < n; o++) begin
         orow = o / (c * s);
         ocol = o % (c * s);
         idx  = (src + (orow / s) * c + ocol / s) % MEM_N;
         check_val($sformatf("%s addr[%0d]", tag, o), wr_addr_q[o], (dst + o) % MEM_N);
         check_val($sformatf("%s data[%0d]", tag, o), wr_data_q[o], int'(mem[idx]));
      end
   endtask

   task automatic run_case(input string tag, input int r, input int c, input int s,
                           input int src, input int dst, input bit hold_start);
      int  cyc, limit;
      bit  zero, seen;
      zero  = (r == 0) || (c == 0) || (s == 0);
      limit = r * s * c * (s + 2) + 20;
      @(negedge clk);
      bus.src_row_size       = DIM_W'(r);
      bus.src_col_size       = DIM_W'(c);
      bus.scale              = SCALE_W'(s);
      bus.src_start_address  = ADDR_W'(src);
      bus.dest_start_address = ADDR_W'(dst);
      wr_addr_q.delete();
      wr_data_q.delete();
      src_write_bad = 0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      check_val({tag, " done@accept"}, int'(bus.done), zero ? 1 : 0);
      if (!hold_start) bus.start = 1'b0;
      // Configuration must already be latched; disturb it for the rest of the run.
      bus.src_row_size       = DIM_W'($urandom_range(1, 63));
      bus.src_col_size       = DIM_W'($urandom_range(1, 63));
      bus.scale              = SCALE_W'($urandom_range(1, 7));
      bus.src_start_address  = ADDR_W'($urandom);
      bus.dest_start_address = ADDR_W'($urandom);
      cyc  = 0;
      seen = bus.done;
      while (!seen && cyc < limit) begin
         @(posedge clk);
         #1;
         cyc++;
         seen = bus.done;
      end
      check_val({tag, " done"}, int'(seen), 1);
      if (zero) check_val({tag, " done<=2"}, int'(cyc <= 2), 1);
      else      check_val({tag, " cycles"}, cyc, r * s * c * (s + 2));
      repeat (hold_start ? 20 : 3) @(posedge clk);
      #1;
      check_val({tag, " done sticky"}, int'(bus.done), 1);
      check_writes(tag, r, c, s, src, dst);
      check_val({tag, " src_write"}, src_write_bad, 0);
      $display("run %s R=%0d C=%0d S=%0d src=%03h dst=%03h writes=%0d cycles=%0d",
               tag, r, c, s, src, dst, wr_addr_q.size(), cyc);
   endtask

   int s1_exp[16] = '{1, 1, -2, -2, 1, 1, -2, -2, 3, 3, 4, 4, 3, 3, 4, 4};

   task automatic check_s1_const(input string tag);
      if (wr_data_q.size() < 16) check_val({tag, " const size"}, wr_data_q.size(), 16);
      else for (int i = 0; i < 16; i++)
         check_val($sformatf("%s const[%0d]", tag, i), wr_data_q[i], s1_exp[i]);
   endtask

   initial begin
      int n, guard;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.src_row_size = '0;
      bus.src_col_size = '0;
      bus.scale = '0;
      bus.src_start_address = 12'h123;
      bus.dest_start_address = 12'h456;
      fill_map(0, MEM_N);
      repeat (3) @(posedge clk);
      #1;
      check_val("reset done", int'(bus.done), 0);
      check_val("reset we", int'(bus.dest_write_en), 0);
      check_val("reset wdata", int'(bus.dest_writedata), 0);
      check_val("reset src_addr", int'(bus.src_address), 'h123);
      check_val("reset dest_addr", int'(bus.dest_address), 'h456);
      reset = 1'b0;

      mem[12'h010] = 16'sd1;
      mem[12'h011] = -16'sd2;
      mem[12'h012] = 16'sd3;
      mem[12'h013] = 16'sd4;
      run_case("s1", 2, 2, 2, 'h010, 'h100, 1'b0);
      check_s1_const("s1");

      mem[12'h200] = 16'sd7;
      mem[12'h201] = 16'sd8;
      mem[12'h202] = 16'sd9;
      run_case("s2", 3, 1, 3, 'h200, 'h300, 1'b0);

      fill_map('h050, 6);
      run_case("wrap", 2, 3, 1, 'h050, 'hFFE, 1'b0);

      run_case("zeroR", 0, 3, 2, 'h020, 'h800, 1'b0);
      run_case("zeroS", 2, 2, 0, 'h020, 'h800, 1'b0);

      // Reset during the 5th write of the first scenario, then a clean rerun.
      @(negedge clk);
      bus.src_row_size = 6'd2;
      bus.src_col_size = 6'd2;
      bus.scale = 3'd2;
      bus.src_start_address = 12'h010;
      bus.dest_start_address = 12'h100;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n = 0;
      guard = 0;
      while (n < 5 && guard < 200) begin
         if (bus.dest_write_en) n++;
         if (n < 5) begin
            @(posedge clk);
            #1;
            guard++;
         end
      end
      check_val("rst reached 5th write", n, 5);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst we", int'(bus.dest_write_en), 0);
      check_val("rst done", int'(bus.done), 0);
      check_val("rst dest_addr", int'(bus.dest_address), 'h100);
      check_val("rst src_addr", int'(bus.src_address), 'h010);
      reset = 1'b0;
      $display("run rst-mid after %0d writes", n);
      run_case("s1again", 2, 2, 2, 'h010, 'h100, 1'b0);
      check_s1_const("s1again");

      fill_map('h400, 4);
      run_case("hold", 2, 2, 2, 'h400, 'h500, 1'b1);
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("hold done after drop", int'(bus.done), 1);

      mem[12'h600] = 16'sh8000;
      mem[12'h601] = 16'sd5;
      run_case("neg", 1, 2, 2, 'h600, 'h700, 1'b0);
      if (wr_data_q.size() > 0) check_val("neg first", wr_data_q[0], -32768);
      else check_val("neg first size", wr_data_q.size(), 1);

      for (int i = 0; i < 8; i++) begin
         int r, c, s, src, dst;
         r   = $urandom_range(1, 4);
         c   = $urandom_range(1, 4);
         s   = $urandom_range(1, 4);
         src = $urandom_range(0, MEM_N - 1);
         dst = $urandom_range(0, MEM_N - 1);
         fill_map(src, r * c);
         run_case($sformatf("rnd%0d", i), r, c, s, src, dst, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
